// File: rtl/mem_stage_lsu_if.sv
// EX->MEM payload, RAM request/response and MEM->WB result bundle for the LSU stage.
// master = the stage itself, slave = the surrounding pipeline and memory.
interface mem_stage_lsu_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RADDR_WIDTH    = 5,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      ex_valid;
    logic                      ex_ready;
    logic [ADDR_WIDTH-1:0]     ex_inst_addr;
    logic [RADDR_WIDTH-1:0]    ex_reg_waddr;
    logic                      ex_reg_we;
    logic [DATA_WIDTH-1:0]     ex_reg_wdata;
    logic [3:0]                ex_mem_op;
    logic [ADDR_WIDTH-1:0]     ex_mem_addr;
    logic [DATA_WIDTH-1:0]     ex_mem_data;
    logic [DATA_WIDTH-1:0]     ex_exception;
    logic                      ex_csr_we;
    logic [CSR_ADDR_WIDTH-1:0] ex_csr_waddr;
    logic [DATA_WIDTH-1:0]     ex_csr_wdata;

    logic                      ram_req;
    logic                      ram_we;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [3:0]                ram_be;
    logic [DATA_WIDTH-1:0]     ram_wdata;
    logic                      ram_gnt;
    logic                      ram_rvalid;
    logic [DATA_WIDTH-1:0]     ram_rdata;

    logic                      wb_valid;
    logic [ADDR_WIDTH-1:0]     wb_inst_addr;
    logic [RADDR_WIDTH-1:0]    wb_reg_waddr;
    logic                      wb_reg_we;
    logic [DATA_WIDTH-1:0]     wb_reg_wdata;
    logic                      wb_csr_we;
    logic [CSR_ADDR_WIDTH-1:0] wb_csr_waddr;
    logic [DATA_WIDTH-1:0]     wb_csr_wdata;
    logic [DATA_WIDTH-1:0]     wb_exception;
    logic                      stall;

    modport master (
        input  ex_valid, ex_inst_addr, ex_reg_waddr, ex_reg_we, ex_reg_wdata, ex_mem_op,
               ex_mem_addr, ex_mem_data, ex_exception, ex_csr_we, ex_csr_waddr, ex_csr_wdata,
               ram_gnt, ram_rvalid, ram_rdata,
        output ex_ready, ram_req, ram_we, ram_addr, ram_be, ram_wdata,
               wb_valid, wb_inst_addr, wb_reg_waddr, wb_reg_we, wb_reg_wdata,
               wb_csr_we, wb_csr_waddr, wb_csr_wdata, wb_exception, stall
    );

    modport slave (
        output ex_valid, ex_inst_addr, ex_reg_waddr, ex_reg_we, ex_reg_wdata, ex_mem_op,
               ex_mem_addr, ex_mem_data, ex_exception, ex_csr_we, ex_csr_waddr, ex_csr_wdata,
               ram_gnt, ram_rvalid, ram_rdata,
        input  ex_ready, ram_req, ram_we, ram_addr, ram_be, ram_wdata,
               wb_valid, wb_inst_addr, wb_reg_waddr, wb_reg_we, wb_reg_wdata,
               wb_csr_we, wb_csr_waddr, wb_csr_wdata, wb_exception, stall
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// Registered MEM stage: aligns/extends RAM accesses, flags misalignment and bus timeouts.
// valid 1 cycle after transfer (no bus) or gnt/rvalid-dependent; ready low from transfer until DONE exits.
module mem_stage_lsu #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int RADDR_WIDTH    = 5,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk_i,
    input logic             rst_ni,
    mem_stage_lsu_if.master bus
);
    localparam logic [3:0] OP_LB  = 4'h0;
    localparam logic [3:0] OP_LH  = 4'h1;
    localparam logic [3:0] OP_LW  = 4'h2;
    localparam logic [3:0] OP_LBU = 4'h4;
    localparam logic [3:0] OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB  = 4'h8;
    localparam logic [3:0] OP_SH  = 4'h9;
    localparam logic [3:0] OP_SW  = 4'hA;

    localparam logic [DATA_WIDTH-1:0] EXC_LD_MISAL = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] EXC_LD_FAULT = DATA_WIDTH'(5);
    localparam logic [DATA_WIDTH-1:0] EXC_ST_MISAL = DATA_WIDTH'(6);
    localparam logic [DATA_WIDTH-1:0] EXC_ST_FAULT = DATA_WIDTH'(7);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]     inst_addr;
        logic [RADDR_WIDTH-1:0]    reg_waddr;
        logic [CSR_ADDR_WIDTH-1:0] csr_waddr;
        logic [DATA_WIDTH-1:0]     csr_wdata;
    } pass_t;

    state_t             state;
    pass_t              pass_q;
    logic [3:0]         op_q;
    logic [1:0]         lane_q;
    logic               reg_we_q;
    logic               csr_we_q;
    logic [CNT_W-1:0]   cnt;

    logic                  xfer, is_load, is_store, misal, timeout_hit;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] sdata, rshift, load_val;

    assign xfer        = bus.ex_valid & bus.ex_ready;
    assign lane        = bus.ex_mem_addr[1:0];
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign sdata       = bus.ex_mem_data << {lane, 3'b000};
    assign rshift      = bus.ram_rdata >> {lane_q, 3'b000};
    assign bus.stall   = ~bus.ex_ready;

    assign bus.wb_inst_addr = pass_q.inst_addr;
    assign bus.wb_reg_waddr = pass_q.reg_waddr;
    assign bus.wb_csr_waddr = pass_q.csr_waddr;
    assign bus.wb_csr_wdata = pass_q.csr_wdata;

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        misal    = 1'b0;
        be       = 4'b1111;
        case (bus.ex_mem_op)
            OP_LB, OP_LBU: begin is_load = 1'b1; be = 4'b0001 << lane; end
            OP_SB:         begin is_store = 1'b1; be = 4'b0001 << lane; end
            OP_LH, OP_LHU: begin is_load = 1'b1; be = 4'b0011 << lane; misal = lane[0]; end
            OP_SH:         begin is_store = 1'b1; be = 4'b0011 << lane; misal = lane[0]; end
            OP_LW:         begin is_load = 1'b1; misal = |lane; end
            OP_SW:         begin is_store = 1'b1; misal = |lane; end
            default: ;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_LB:   load_val = {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
            OP_LBU:  load_val = {{(DATA_WIDTH-8){1'b0}}, rshift[7:0]};
            OP_LH:   load_val = {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
            OP_LHU:  load_val = {{(DATA_WIDTH-16){1'b0}}, rshift[15:0]};
            default: load_val = bus.ram_rdata;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            pass_q           <= '0;
            op_q             <= '0;
            lane_q           <= '0;
            reg_we_q         <= 1'b0;
            csr_we_q         <= 1'b0;
            cnt              <= '0;
            bus.ex_ready     <= 1'b0;
            bus.ram_req      <= 1'b0;
            bus.ram_we       <= 1'b0;
            bus.ram_addr     <= '0;
            bus.ram_be       <= '0;
            bus.ram_wdata    <= '0;
            bus.wb_valid     <= 1'b0;
            bus.wb_reg_we    <= 1'b0;
            bus.wb_reg_wdata <= '0;
            bus.wb_csr_we    <= 1'b0;
            bus.wb_exception <= '0;
        end else begin
            bus.wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.ex_ready <= ~xfer;
                    if (xfer) begin
                        pass_q           <= '{bus.ex_inst_addr, bus.ex_reg_waddr,
                                              bus.ex_csr_waddr, bus.ex_csr_wdata};
                        bus.wb_reg_wdata <= bus.ex_reg_wdata;
                        op_q             <= bus.ex_mem_op;
                        lane_q           <= lane;
                        reg_we_q         <= bus.ex_reg_we;
                        csr_we_q         <= bus.ex_csr_we;
                        cnt              <= '0;
                        bus.ram_we       <= is_store;
                        bus.ram_addr     <= {bus.ex_mem_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus.ram_be       <= be;
                        bus.ram_wdata    <= sdata;
                        // Early-out order encodes precedence: upstream exception, then misalignment.
                        if (bus.ex_exception != '0) begin
                            state            <= DONE;
                            bus.wb_valid     <= 1'b1;
                            bus.wb_exception <= bus.ex_exception;
                            bus.wb_reg_we    <= 1'b0;
                            bus.wb_csr_we    <= 1'b0;
                        end else if (!(is_load || is_store)) begin
                            state            <= DONE;
                            bus.wb_valid     <= 1'b1;
                            bus.wb_exception <= '0;
                            bus.wb_reg_we    <= bus.ex_reg_we;
                            bus.wb_csr_we    <= bus.ex_csr_we;
                        end else if (misal) begin
                            state            <= DONE;
                            bus.wb_valid     <= 1'b1;
                            bus.wb_exception <= is_store ? EXC_ST_MISAL : EXC_LD_MISAL;
                            bus.wb_reg_we    <= 1'b0;
                            bus.wb_csr_we    <= 1'b0;
                        end else begin
                            state       <= REQ;
                            bus.ram_req <= 1'b1;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (state == WAIT && bus.ram_rvalid) begin
                        state            <= DONE;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_exception <= '0;
                        bus.wb_reg_we    <= reg_we_q & ~bus.ram_we;
                        bus.wb_csr_we    <= csr_we_q;
                        if (!bus.ram_we) bus.wb_reg_wdata <= load_val;
                    end else if (timeout_hit) begin
                        state            <= DONE;
                        bus.ram_req      <= 1'b0;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_exception <= bus.ram_we ? EXC_ST_FAULT : EXC_LD_FAULT;
                        bus.wb_reg_we    <= 1'b0;
                        bus.wb_csr_we    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // rvalid cannot accompany gnt, so WAIT only starts looking a cycle later.
                        if (state == REQ && bus.ram_gnt) begin
                            state       <= WAIT;
                            bus.ram_req <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    bus.ex_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a transaction-level model predicts bus requests and WB results.
module tb_mem_stage_lsu;
    localparam int TO = 4;
    localparam logic [3:0] OP_LB = 4'h0, OP_LH = 4'h1, OP_LW = 4'h2, OP_LBU = 4'h4, OP_LHU = 4'h5;
    localparam logic [3:0] OP_SB = 4'h8, OP_SH = 4'h9, OP_SW = 4'hA, OP_ALU = 4'hF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_stage_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .CSR_ADDR_WIDTH(12)) ifc ();

    mem_stage_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .RADDR_WIDTH(5), .CSR_ADDR_WIDTH(12),
                    .TIMEOUT_CYCLES(TO)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(ifc.master));

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, data, exc, rwd, rdata, iaddr, cwd;
        logic        rwe, cwe;
        logic [4:0]  waddr;
        logic [11:0] caddr;
        int          g, r;
    } stim_t;

    typedef struct {
        int          cyc, lat;
        logic [31:0] exc, rwd, iaddr, cwd;
        logic        rwe, cwe;
        logic [4:0]  waddr;
        logic [11:0] caddr;
        bit          bus;
        logic [31:0] baddr, bwdata;
        logic [3:0]  be;
        logic        bwe;
    } exp_t;

    exp_t exp_q[$];
    int cyc = 0;
    int n_pass = 0, n_tot = 0;
    int trans_cyc = 0, valid_cnt = 0, req_cnt = 0;
    int last_valid_cyc = 0, prev_valid_cyc = 0;
    logic [31:0] last_wdata, last_exc, last_baddr, last_bwdata;
    logic [3:0]  last_be;
    logic        last_reg_we;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tot++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic bound_fail(input string nm);
        n_tot++;
        $display("FAIL %s: bounded wait expired at cycle %0d", nm, cyc);
    endtask

    function automatic stim_t mk(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] rdata, input int g, input int r);
        stim_t s;
        s.op = op; s.addr = addr; s.data = data; s.rdata = rdata; s.g = g; s.r = r;
        s.exc = 0; s.rwe = 1'b1; s.cwe = 1'b1;
        s.rwd = 32'h1111_0000 ^ addr; s.iaddr = 32'h8000_0000 + addr;
        s.cwd = data ^ 32'h5A5A_5A5A; s.waddr = 5'd7 + 5'(addr[2:0]); s.caddr = 12'h300 + 12'(op);
        return s;
    endfunction

    // Transaction-level view: access size, lane, alignment and bus-cycle budget.
    function automatic exp_t model(input stim_t s);
        exp_t e;
        bit ld, st, sgn;
        int size, lane;
        logic [31:0] mask, v;
        ld = s.op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
        st = s.op inside {OP_SB, OP_SH, OP_SW};
        sgn = s.op inside {OP_LB, OP_LH};
        size = (s.op inside {OP_LB, OP_LBU, OP_SB}) ? 1 : (s.op inside {OP_LH, OP_LHU, OP_SH}) ? 2 : 4;
        lane = int'(s.addr % 4);
        mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
        e.cyc = 0; e.lat = 1; e.bus = 0;
        e.iaddr = s.iaddr; e.waddr = s.waddr; e.caddr = s.caddr; e.cwd = s.cwd; e.rwd = s.rwd;
        e.baddr = s.addr - 32'(lane); e.be = 4'((32'd1 << size) - 1) << lane;
        e.bwdata = s.data << (8 * lane); e.bwe = st;
        if (s.exc != 0) begin
            e.exc = s.exc; e.rwe = 0;
        end else if (!ld && !st) begin
            e.exc = 0; e.rwe = s.rwe;
        end else if (lane % size != 0) begin
            e.exc = ld ? 32'd4 : 32'd6; e.rwe = 0;
        end else begin
            e.bus = 1;
            if (s.g + 1 + s.r > TO) begin
                e.exc = ld ? 32'd5 : 32'd7; e.rwe = 0; e.lat = 1 + TO;
            end else begin
                e.exc = 0; e.lat = s.g + 2 + s.r; e.rwe = ld ? s.rwe : 1'b0;
                if (ld) begin
                    v = (s.rdata >> (8 * lane)) & mask;
                    if (sgn && v[8*size-1]) v = v | ~mask;
                    e.rwd = v;
                end
            end
        end
        e.cwe = (e.exc == 0) ? s.cwe : 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.ram_req) begin
                req_cnt++;
                if (exp_q.size() == 0 || !exp_q[0].bus) chk("ram_req_unexpected", ifc.ram_req, 1'b0);
                else begin
                    chk("ram_addr", ifc.ram_addr, exp_q[0].baddr);
                    chk("ram_we", 32'(ifc.ram_we), 32'(exp_q[0].bwe));
                    if (exp_q[0].bwe) begin
                        chk("ram_be", 32'(ifc.ram_be), 32'(exp_q[0].be));
                        chk("ram_wdata", ifc.ram_wdata, exp_q[0].bwdata);
                    end
                end
                last_baddr = ifc.ram_addr; last_be = ifc.ram_be; last_bwdata = ifc.ram_wdata;
            end
            if (ifc.wb_valid) begin
                exp_t e;
                valid_cnt++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                last_wdata = ifc.wb_reg_wdata; last_exc = ifc.wb_exception; last_reg_we = ifc.wb_reg_we;
                if (exp_q.size() == 0) chk("valid_unexpected", 32'(ifc.wb_valid), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("valid_cycle", 32'(cyc), 32'(e.cyc));
                    chk("exception", ifc.wb_exception, e.exc);
                    chk("reg_we", 32'(ifc.wb_reg_we), 32'(e.rwe));
                    if (e.rwe) chk("reg_wdata", ifc.wb_reg_wdata, e.rwd);
                    chk("csr_we", 32'(ifc.wb_csr_we), 32'(e.cwe));
                    chk("inst_addr", ifc.wb_inst_addr, e.iaddr);
                    chk("reg_waddr", 32'(ifc.wb_reg_waddr), 32'(e.waddr));
                    chk("csr_waddr", 32'(ifc.wb_csr_waddr), 32'(e.caddr));
                    chk("csr_wdata", ifc.wb_csr_wdata, e.cwd);
                    chk("stall_in_done", 32'(ifc.stall), 32'd1);
                end
            end
        end
    end

    task automatic set_ex(input stim_t s);
        ifc.ex_mem_op = s.op; ifc.ex_mem_addr = s.addr; ifc.ex_mem_data = s.data;
        ifc.ex_exception = s.exc; ifc.ex_reg_we = s.rwe; ifc.ex_reg_wdata = s.rwd;
        ifc.ex_inst_addr = s.iaddr; ifc.ex_reg_waddr = s.waddr; ifc.ex_csr_we = s.cwe;
        ifc.ex_csr_waddr = s.caddr; ifc.ex_csr_wdata = s.cwd; ifc.ram_rdata = s.rdata;
    endtask

    // Called at a negedge; returns at a negedge once the result has been consumed.
    task automatic run_op(input stim_t s);
        exp_t e;
        int w;
        set_ex(s);
        ifc.ex_valid = 1'b1;
        w = 0;
        while (!ifc.ex_ready && w < 20) begin @(negedge clk); w++; end
        if (!ifc.ex_ready) begin
            bound_fail("accept_wait");
            ifc.ex_valid = 1'b0;
            return;
        end
        e = model(s);
        e.cyc = cyc + e.lat;
        trans_cyc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 ifc.ex_valid = 1'b0;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
            ifc.ram_gnt    = e.bus && (n == s.g + 1);
            ifc.ram_rvalid = e.bus && (n == s.g + 1 + s.r);
        end
        ifc.ram_gnt = 1'b0;
        ifc.ram_rvalid = 1'b0;
        if (exp_q.size() != 0) begin
            bound_fail("valid_wait");
            exp_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        stim_t s;
        exp_t e;
        int vc;
        ifc.ex_valid = 0; ifc.ram_gnt = 0; ifc.ram_rvalid = 0;
        set_ex(mk(OP_ALU, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ifc.ex_ready), 32'd0);
        chk("rst_ram_req", 32'(ifc.ram_req), 32'd0);
        chk("rst_valid", 32'(ifc.wb_valid), 32'd0);
        chk("rst_exception", ifc.wb_exception, 32'd0);
        chk("rst_reg_we", 32'(ifc.wb_reg_we), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", 32'(ifc.ex_ready), 32'd1);

        run_op(mk(OP_LW, 32'h100, 0, 32'hDEAD_BEEF, 0, 1));
        chk("lw_latency", 32'(last_valid_cyc - trans_cyc + 1), 32'd3);
        chk("lw_data", last_wdata, 32'hDEAD_BEEF);
        chk("lw_reg_we", 32'(last_reg_we), 32'd1);

        run_op(mk(OP_LB, 32'h103, 0, 32'h8011_2233, 0, 1));
        chk("lb_sext", last_wdata, 32'hFFFF_FF80);
        run_op(mk(OP_LBU, 32'h103, 0, 32'h8011_2233, 0, 1));
        chk("lbu_zext", last_wdata, 32'h0000_0080);

        run_op(mk(OP_SH, 32'h102, 32'h0000_ABCD, 0, 0, 1));
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_bwdata, 32'hABCD_0000);
        chk("sh_addr", last_baddr, 32'h100);
        chk("sh_reg_we", 32'(last_reg_we), 32'd0);

        vc = req_cnt;
        run_op(mk(OP_LW, 32'h101, 0, 0, 0, 1));
        chk("lw_mis_no_req", 32'(req_cnt - vc), 32'd0);
        chk("lw_mis_latency", 32'(last_valid_cyc - trans_cyc + 1), 32'd1);
        chk("lw_mis_exc", last_exc, 32'd4);

        run_op(mk(OP_SH, 32'h101, 32'h1234, 0, 0, 1));
        chk("sh_mis_exc", last_exc, 32'd6);
        run_op(mk(OP_LH, 32'h102, 0, 32'h8001_7FFF, 1, 2));
        chk("lh_hi_sext_edge", last_wdata, 32'hFFFF_8001);
        run_op(mk(OP_LHU, 32'h100, 0, 32'h8001_F00D, 2, 1));
        run_op(mk(OP_SB, 32'h201, 32'h0000_00A5, 0, 0, 2));
        chk("sb_be", 32'(last_be), 32'h2);
        run_op(mk(OP_SW, 32'h204, 32'hCAFE_F00D, 0, 1, 1));
        run_op(mk(OP_ALU, 32'h0, 32'h0, 0, 0, 0));
        s = mk(OP_ALU, 32'h10, 32'h3, 0, 0, 0); s.exc = 32'd2;
        run_op(s);
        chk("alu_exc_fwd", last_exc, 32'd2);
        s = mk(OP_LW, 32'h101, 0, 0, 0, 1); s.exc = 32'd3;
        run_op(s);
        chk("exc_over_misal", last_exc, 32'd3);

        run_op(mk(OP_LW, 32'h300, 0, 32'h1234_5678, 1, 3));
        chk("lw_timeout_exc", last_exc, 32'd5);

        run_op(mk(OP_SW, 32'h304, 32'h5555_AAAA, 0, 99, 1));
        chk("sw_timeout_exc", last_exc, 32'd7);
        chk("sw_timeout_latency", 32'(last_valid_cyc - trans_cyc + 1), 32'd5);
        vc = valid_cnt;
        ifc.ram_rvalid = 1'b1;
        @(negedge clk);
        ifc.ram_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("stale_rvalid_ignored", 32'(valid_cnt - vc), 32'd0);
        run_op(mk(OP_ALU, 32'h44, 32'h9, 0, 0, 0));

        // Back-to-back ALU ops with valid held high: second transfer two cycles after the first.
        s = mk(OP_ALU, 32'h50, 32'h1, 0, 0, 0);
        set_ex(s);
        ifc.ex_valid = 1'b1;
        e = model(s); e.cyc = cyc + 1; exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        s = mk(OP_ALU, 32'h60, 32'h2, 0, 0, 0);
        set_ex(s);
        e = model(s); e.cyc = cyc + 2; exp_q.push_back(e);
        @(posedge clk);
        @(posedge clk);
        #1 ifc.ex_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd2);
        if (exp_q.size() != 0) begin bound_fail("b2b_drain"); exp_q.delete(); end

        // Reset asserted while the load sits in WAIT.
        s = mk(OP_LW, 32'h400, 0, 32'hFFFF_FFFF, 0, 99);
        set_ex(s);
        ifc.ex_valid = 1'b1;
        e = model(s); e.cyc = cyc + e.lat; exp_q.push_back(e);
        @(posedge clk);
        #1 ifc.ex_valid = 1'b0;
        @(negedge clk);
        ifc.ram_gnt = 1'b1;
        @(negedge clk);
        ifc.ram_gnt = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_ram_req", 32'(ifc.ram_req), 32'd0);
        chk("rstw_ram_addr", ifc.ram_addr, 32'd0);
        chk("rstw_ready", 32'(ifc.ex_ready), 32'd0);
        chk("rstw_valid", 32'(ifc.wb_valid), 32'd0);
        chk("rstw_inst_addr", ifc.wb_inst_addr, 32'd0);
        chk("rstw_reg_wdata", ifc.wb_reg_wdata, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstw_ready_after", 32'(ifc.ex_ready), 32'd1);
        run_op(mk(OP_LH, 32'h402, 0, 32'h7FFF_0000, 0, 1));
        chk("post_rst_lh", last_wdata, 32'h0000_7FFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
